// File: rtl/acc_pkg.sv
// Shared types and constants for the multiply-add accelerator front end.
package acc_pkg;

  localparam int unsigned ACC_DATA_W = 16;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    ARMED  = 2'd1,
    STREAM = 2'd2
  } loader_state_e;

  // Occupancy counter width: one extra MSB so full and empty differ.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/acc_ring_buffer.sv
// Circular word store with wrapping pointers and occupancy count.
module acc_ring_buffer
  import acc_pkg::*;
#(
  parameter int unsigned DATA_W = ACC_DATA_W,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/acc_input_loader.sv
// Host-side input loader: buffers words, arms the controller, pops onto v_bus.
// Optional stall counter enabled by defining ACC_LOADER_STATS_EN.
module acc_input_loader
  import acc_pkg::*;
#(
  parameter int unsigned DATA_W    = ACC_DATA_W,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned RDY_LEVEL = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic [DATA_W-1:0]      s_data_i,
  output logic                   data_rdy_o,
  input  logic                   read_en_i,
  output logic [DATA_W-1:0]      v_bus_o,
  output logic                   v_bus_vld_o,
  output logic                   underflow_o,
  output logic [$clog2(DEPTH):0] level_o
`ifdef ACC_LOADER_STATS_EN
  ,
  output logic [15:0]            stall_cnt_o
`endif
);

  localparam int unsigned CW = cnt_width(DEPTH);

  loader_state_e     state_q;
  loader_state_e     state_d;
  logic              wr_en;
  logic              rd_en;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] rd_data;

  // No write-through on full: a same-cycle pop does not open the input.
  assign s_ready_o = !full;
  assign wr_en     = s_valid_i && !full;
  assign rd_en     = read_en_i && !empty;
  assign level_o   = count;

  acc_ring_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ring (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (s_data_i),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Popped-word register and sticky underflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_bus_o     <= '0;
      v_bus_vld_o <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      v_bus_vld_o <= rd_en;
      if (rd_en) begin
        v_bus_o <= rd_data;
      end
      if (read_en_i && empty) begin
        underflow_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (count >= CW'(RDY_LEVEL)) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (read_en_i) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        // Leave once the last buffered word is popped with nothing refilling it.
        if ((rd_en && !wr_en && (count == CW'(1))) || empty) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    data_rdy_o = 1'b0;
    if (state_q != FILL) begin
      data_rdy_o = 1'b1;
    end
  end

`ifdef ACC_LOADER_STATS_EN
  logic [15:0] stall_q;

  // Saturating count of cycles the sender was held off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (s_valid_i && full && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_acc_input_loader.sv
// Self-checking bench for acc_input_loader against a queue-based reference model.
module tb_acc_input_loader;

  localparam int DATA_W    = 16;
  localparam int DEPTH     = 64;
  localparam int RDY_LEVEL = 32;

  logic              clk;
  logic              rst_n;
  logic              s_valid_i;
  logic              s_ready_o;
  logic [DATA_W-1:0] s_data_i;
  logic              data_rdy_o;
  logic              read_en_i;
  logic [DATA_W-1:0] v_bus_o;
  logic              v_bus_vld_o;
  logic              underflow_o;
  logic [6:0]        level_o;
`ifdef ACC_LOADER_STATS_EN
  logic [15:0]       stall_cnt_o;
`endif

  acc_input_loader #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .RDY_LEVEL (RDY_LEVEL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .s_data_i    (s_data_i),
    .data_rdy_o  (data_rdy_o),
    .read_en_i   (read_en_i),
    .v_bus_o     (v_bus_o),
    .v_bus_vld_o (v_bus_vld_o),
    .underflow_o (underflow_o),
    .level_o     (level_o)
`ifdef ACC_LOADER_STATS_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] m_vbus;
  logic              m_vld;
  logic              m_uf;
  logic              m_rdy;
  logic              m_stream;
  int                m_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle, advance the model across the edge, then compare.
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic re, input logic rn);
    int  cnt;
    logic acc;
    logic pop;
    s_valid_i = v;
    s_data_i  = d;
    read_en_i = re;
    rst_n     = rn;
    cnt = mq.size();
    acc = v && (cnt < DEPTH);
    pop = re && (cnt > 0);
    @(posedge clk);
    if (!rn) begin
      mq.delete();
      m_vbus = '0; m_vld = 1'b0; m_uf = 1'b0;
      m_rdy = 1'b0; m_stream = 1'b0; m_stall = 0;
    end else begin
      if (!m_rdy) begin
        if (cnt >= RDY_LEVEL) m_rdy = 1'b1;
      end else if (!m_stream) begin
        if (re) m_stream = 1'b1;
      end else if ((pop && !acc && cnt == 1) || cnt == 0) begin
        m_rdy = 1'b0; m_stream = 1'b0;
      end
      if (v && cnt == DEPTH && m_stall < 65535) m_stall++;
      m_vld = pop;
      if (pop) m_vbus = mq.pop_front();
      if (re && cnt == 0) m_uf = 1'b1;
      if (acc) mq.push_back(d);
    end
    #1;
    chk("level", 32'(level_o), 32'(mq.size()));
    chk("s_ready", 32'(s_ready_o), 32'(mq.size() < DEPTH));
    chk("data_rdy", 32'(data_rdy_o), 32'(m_rdy));
    chk("v_bus_vld", 32'(v_bus_vld_o), 32'(m_vld));
    chk("v_bus", 32'(v_bus_o), 32'(m_vbus));
    chk("underflow", 32'(underflow_o), 32'(m_uf));
`ifdef ACC_LOADER_STATS_EN
    chk("stall_cnt", 32'(stall_cnt_o), 32'(m_stall));
`endif
  endtask

  initial begin
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] last_v;
    s_valid_i = 1'b0; s_data_i = '0; read_en_i = 1'b0; rst_n = 1'b0;
    mq.delete();
    m_vbus = '0; m_vld = 1'b0; m_uf = 1'b0; m_rdy = 1'b0; m_stream = 1'b0; m_stall = 0;

    // Reset state
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_ready", 32'(s_ready_o), 32'd1);
    chk("rst_rdy", 32'(data_rdy_o), 32'd0);

    // Arm with 0x0001..0x0020
    for (int i = 1; i <= 32; i++) begin
      step(1'b1, 16'(i), 1'b0, 1'b1);
      chk("arm_ready", 32'(s_ready_o), 32'd1);
    end
    chk("arm_level", 32'(level_o), 32'd32);
    chk("arm_rdy_not_yet", 32'(data_rdy_o), 32'd0);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("arm_rdy_rise", 32'(data_rdy_o), 32'd1);

    // Pop ordering
    for (int i = 1; i <= 32; i++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      chk("pop_order", 32'(v_bus_o), 32'(i));
      chk("pop_vld", 32'(v_bus_vld_o), 32'd1);
    end
    chk("pop_back_to_fill", 32'(data_rdy_o), 32'd0);
    step(1'b0, '0, 1'b0, 1'b1);

    // Full, stall counting and simultaneous accept/pop
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 16'($urandom), 1'b0, 1'b1);
    chk("full_ready", 32'(s_ready_o), 32'd0);
    chk("full_level", 32'(level_o), 32'd64);
    hold = 16'($urandom);
    for (int i = 0; i < 10; i++) step(1'b1, hold, 1'b0, 1'b1);
`ifdef ACC_LOADER_STATS_EN
    chk("stall_10", 32'(stall_cnt_o), 32'd10);
`endif
    step(1'b1, hold, 1'b1, 1'b1);
    chk("full_pop_no_accept", 32'(level_o), 32'd63);
    step(1'b1, hold, 1'b1, 1'b1);
    chk("simul_level", 32'(level_o), 32'd63);
    while (mq.size() > 0) step(1'b0, '0, 1'b1, 1'b1);

    // Wrap: push 48, pop 40, push 40
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 48; i++) step(1'b1, 16'(i), 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b1, 1'b1);
    for (int i = 49; i <= 88; i++) step(1'b1, 16'(i), 1'b0, 1'b1);
    chk("wrap_level", 32'(level_o), 32'd48);
    for (int i = 41; i <= 88; i++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      chk("wrap_order", 32'(v_bus_o), 32'(i));
    end

    // Underflow on empty pop
    last_v = 16'd88;
    step(1'b0, '0, 1'b1, 1'b1);
    chk("uf_vld", 32'(v_bus_vld_o), 32'd0);
    chk("uf_hold_bus", 32'(v_bus_o), 32'(last_v));
    chk("uf_set", 32'(underflow_o), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);
    chk("uf_sticky", 32'(underflow_o), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 9) < 6), 16'($urandom), 1'($urandom_range(0, 9) < 4), 1'b1);
    end

    // Reset mid-stream at level 20
    while (mq.size() > 20) step(1'b0, '0, 1'b1, 1'b1);
    while (mq.size() < 20) step(1'b1, 16'($urandom), 1'b0, 1'b1);
    chk("pre_rst_level", 32'(level_o), 32'd20);
    chk("pre_rst_uf", 32'(underflow_o), 32'd1);
    step(1'b1, 16'($urandom), 1'b1, 1'b0);
    chk("mid_rst_level", 32'(level_o), 32'd0);
    chk("mid_rst_rdy", 32'(data_rdy_o), 32'd0);
    chk("mid_rst_uf", 32'(underflow_o), 32'd0);
    step(1'b0, '0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
